// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared shift-op encodings and shift_unit FSM state encodings
package alu_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift/rotate by a fixed DIST positions, selected by op_i
module shift_step
  import alu_pkg::*;
#(
  parameter int unsigned DIST = 1
) (
  input  shift_op_e   op_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SLL:  data_o = data_i << DIST;
      OP_SRL:  data_o = data_i >> DIST;
      OP_SRA:  data_o = 32'($signed(data_i) >>> DIST);
      OP_ROR:  data_o = (data_i >> DIST) | (data_i << (32 - DIST));
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - iterative 32-bit shifter (IDLE/SHIFT/DONE), one bit per cycle
// SHIFT_UNIT_FAST_EN selects a single-cycle log2 barrel shifter instead.
module shift_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  shift_op,
  input  logic [4:0]  shift_amt,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  shift_op_e   op_q, op_d;
  logic [31:0] work_q, work_d;
  logic [31:0] data_out_q, data_out_d;
  logic [31:0] step_res;
  logic        accept;
  shift_op_e   op_in;

  assign op_in  = shift_op_e'(shift_op);
  assign accept = start && (state_q != ST_SHIFT);

  shift_step #(.DIST(1)) u_step (
    .op_i   (op_q),
    .data_i (work_q),
    .data_o (step_res)
  );

`ifdef SHIFT_UNIT_FAST_EN
  logic [31:0] stage [0:5];
  logic [31:0] barrel_res;

  assign stage[0] = data_in;
  // stage k conditionally applies a 2**k step, gated by shift_amt[k]
  for (genvar k = 0; k < 5; k++) begin : g_barrel
    logic [31:0] shifted;
    shift_step #(.DIST(1 << k)) u_stage (
      .op_i   (op_in),
      .data_i (stage[k]),
      .data_o (shifted)
    );
    assign stage[k+1] = shift_amt[k] ? shifted : stage[k];
  end
  assign barrel_res = stage[5];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    work_d     = work_q;
    data_out_d = data_out_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          op_d = op_in;
`ifdef SHIFT_UNIT_FAST_EN
          cnt_d      = 5'd0;
          work_d     = barrel_res;
          data_out_d = barrel_res;
          state_d    = ST_DONE;
`else
          cnt_d  = shift_amt;
          work_d = data_in;
          if (shift_amt == 5'd0) begin
            data_out_d = data_in;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
`endif
        end
      end
      ST_SHIFT: begin
        work_d = step_res;
        cnt_d  = cnt_q - 5'd1;
        // result becomes visible only on the final step
        if (cnt_q == 5'd1) begin
          data_out_d = step_res;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      op_q       <= OP_SLL;
      work_q     <= 32'h0;
      data_out_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      work_q     <= work_d;
      data_out_q <= data_out_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);
  assign data_out = data_out_q;

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - directed self-checking bench for shift_unit (honours SHIFT_UNIT_FAST_EN)
module tb_shift_unit;

`ifdef SHIFT_UNIT_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  shift_op;
  logic [4:0]  shift_amt;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  shift_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .shift_op  (shift_op),
    .shift_amt (shift_amt),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives a command for exactly one rising edge; caller positions time away from the edge.
  task automatic send(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] d);
    start     = 1'b1;
    shift_op  = op;
    shift_amt = amt;
    data_in   = d;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done; k=1 is the first cycle after that edge.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                           input logic [31:0] exp_data);
    int k;
    int bcnt;
    logic overlap;
    bit seen;
    bcnt    = 0;
    overlap = 1'b0;
    seen    = 1'b0;
    k       = 0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (busy && done) overlap = 1'b1;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
    check({tag, "_lat"},  32'(k),    32'(exp_lat));
    check({tag, "_busy"}, 32'(bcnt), 32'(exp_busy));
    check({tag, "_ovl"},  {31'b0, overlap}, 32'h0);
    check({tag, "_data"}, data_out, exp_data);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [4:0] amt,
                        input logic [31:0] d, input logic [31:0] exp);
    @(negedge clk);
    send(op, amt, d);
    wait_done(tag, FAST ? 1 : int'(amt) + 1, FAST ? 0 : int'(amt), exp);
  endtask

  initial begin
    int dcnt;
    reset     = 1'b1;
    start     = 1'b0;
    shift_op  = 2'b00;
    shift_amt = 5'd0;
    data_in   = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_dout", data_out, 32'h0);

    run_op("sll4",    2'b00, 5'd4,  32'h0000_0001, 32'h0000_0010);
    run_op("sra31",   2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("srl31",   2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001);
    run_op("ror1",    2'b11, 5'd1,  32'h0000_0001, 32'h8000_0000);
    run_op("amt0",    2'b11, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_op("sll31",   2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
    run_op("srl4",    2'b01, 5'd4,  32'hF000_0000, 32'h0F00_0000);
    run_op("sra4",    2'b10, 5'd4,  32'hF000_0000, 32'hFF00_0000);
    run_op("ror8",    2'b11, 5'd8,  32'h1234_5678, 32'h7812_3456);
    run_op("sll8",    2'b00, 5'd8,  32'h1234_5678, 32'h3456_7800);
    run_op("sra_pos", 2'b10, 5'd3,  32'h4000_0000, 32'h0800_0000);

    // back-to-back: new command issued in the DONE cycle
    run_op("b2b_a", 2'b00, 5'd2, 32'h0000_0003, 32'h0000_000C);
    send(2'b01, 5'd3, 32'h0000_0100);
    wait_done("b2b_b", FAST ? 1 : 4, FAST ? 0 : 3, 32'h0000_0020);

`ifndef SHIFT_UNIT_FAST_EN
    // start during SHIFT is ignored and data_out holds the previous result
    @(negedge clk);
    send(2'b00, 5'd4, 32'h0000_0001);
    @(negedge clk);
    check("ign_hold", data_out, 32'h0000_0020);
    check("ign_busy", {31'b0, busy}, 32'h1);
    send(2'b01, 5'd1, 32'hFFFF_FFFF);
    shift_op  = 2'b00;
    shift_amt = 5'd0;
    data_in   = 32'h0;
    wait_done("ign", 4, 3, 32'h0000_0010);
    @(negedge clk);
    check("ign_idle", {30'b0, done, busy}, 32'h0);

    // reset sampled two edges into an amt=10 shift
    @(negedge clk);
    send(2'b00, 5'd10, 32'h0000_0001);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rmid_busy", {31'b0, busy}, 32'h0);
    check("rmid_done", {31'b0, done}, 32'h0);
    check("rmid_dout", data_out, 32'h0);
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("rmid_nodone", 32'(dcnt), 32'h0);
`endif

    // reset wins over start on the same edge
    run_op("pre_rp", 2'b11, 5'd0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    @(negedge clk);
    reset     = 1'b1;
    start     = 1'b1;
    shift_op  = 2'b00;
    shift_amt = 5'd0;
    data_in   = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rprio_done", {31'b0, done}, 32'h0);
    check("rprio_busy", {31'b0, busy}, 32'h0);
    check("rprio_dout", data_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
